// File: rtl/xlr8_dmem_mc_pkg.sv
// Shared definitions for the multi-channel data-memory crossbar: register map,
// control/status bit positions, prefetch states and address stepping.
package xlr8_dmem_mc_pkg;

    localparam logic [8:0] OFF_CTRL   = 9'd0;
    localparam logic [8:0] OFF_STATUS = 9'd1;
    localparam logic [8:0] OFF_CH0    = 9'd2;

    localparam logic [1:0] FLD_ADRL   = 2'd0;
    localparam logic [1:0] FLD_ADRH   = 2'd1;
    localparam logic [1:0] FLD_STRIDE = 2'd2;
    localparam logic [1:0] FLD_DATA   = 2'd3;

    localparam int CTRL_WRAP     = 0;
    localparam int CTRL_CLR      = 1;
    localparam int STAT_OOR      = 6;
    localparam int STAT_UNDERRUN = 7;

    typedef enum logic [1:0] {
        PF_INVAL = 2'd0,
        PF_FETCH = 2'd1,
        PF_VALID = 2'd2
    } pf_state_t;

    // Address plus sign-extended stride; modulo mem_size when wrap is set.
    function automatic logic [15:0] next_addr(input logic [15:0] addr,
                                              input logic [7:0]  stride,
                                              input logic        wrap,
                                              input logic [16:0] mem_size);
        logic signed [17:0] sum;
        logic signed [17:0] size_s;
        size_s = $signed({1'b0, mem_size});
        sum    = $signed({2'b00, addr}) + $signed({{10{stride[7]}}, stride});
        if (!wrap) begin
            next_addr = sum[15:0];
        end else if (sum < 18'sd0) begin
            next_addr = 16'(sum + size_s);
        end else if (sum >= size_s) begin
            next_addr = 16'(sum - size_s);
        end else begin
            next_addr = sum[15:0];
        end
    endfunction

endpackage

// File: rtl/xlr8_dmem_mc_chan.sv
// One address channel: address/stride registers and the prefetch state machine.
module xlr8_dmem_mc_chan
    import xlr8_dmem_mc_pkg::*;
#(
    parameter int MEM_SIZE = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wrap,
    input  logic        i_wr_adrl,
    input  logic        i_wr_adrh,
    input  logic        i_wr_stride,
    input  logic        i_data_acc,
    input  logic        i_hit,
    input  logic [7:0]  i_wdata,
    input  logic        i_grant,
    input  logic [7:0]  i_rdata,
    output logic [15:0] o_addr,
    output logic [7:0]  o_stride,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_req,
    output logic        o_oor
);

    localparam logic [16:0] MEM_SZ = 17'(MEM_SIZE);

    logic [15:0] r_addr;
    logic [7:0]  r_stride;
    logic [7:0]  r_data;
    pf_state_t   r_state;
    pf_state_t   w_state_nxt;
    logic        w_capture;
    logic        w_inval;

    assign w_inval = i_wr_adrl | i_wr_adrh | i_data_acc | i_hit;

    // Address and stride registers; a DATA access steps the address afterwards.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr   <= 16'h0000;
            r_stride <= 8'h01;
        end else begin
            if (i_wr_adrl) begin
                r_addr[7:0] <= i_wdata;
            end else if (i_wr_adrh) begin
                r_addr[15:8] <= i_wdata;
            end else if (i_data_acc) begin
                r_addr <= next_addr(r_addr, r_stride, i_wrap, MEM_SZ);
            end
            if (i_wr_stride) begin
                r_stride <= i_wdata;
            end
        end
    end

    // Prefetch state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= PF_INVAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Prefetch next state; invalidation beats everything, dropping a capture.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            PF_INVAL: begin
                if (w_inval) begin
                    w_state_nxt = PF_INVAL;
                end else if (i_grant) begin
                    w_state_nxt = PF_FETCH;
                end else begin
                    w_state_nxt = PF_INVAL;
                end
            end
            PF_FETCH: begin
                if (w_inval) begin
                    w_state_nxt = PF_INVAL;
                end else begin
                    w_state_nxt = PF_VALID;
                    w_capture   = 1'b1;
                end
            end
            PF_VALID: begin
                if (w_inval) begin
                    w_state_nxt = PF_INVAL;
                end else begin
                    w_state_nxt = PF_VALID;
                end
            end
            default: begin
                w_state_nxt = PF_INVAL;
            end
        endcase
    end

    // Prefetch data register keeps its stale value until the next capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data <= 8'h00;
        end else if (w_capture) begin
            r_data <= i_rdata;
        end
    end

    assign o_addr   = r_addr;
    assign o_stride = r_stride;
    assign o_data   = r_data;
    assign o_valid  = (r_state == PF_VALID);
    assign o_req    = (r_state == PF_INVAL) && !w_inval;
    assign o_oor    = ({1'b0, r_addr} >= MEM_SZ);

endmodule

// File: rtl/xlr8_ram_1p.sv
// Single-port data memory with one-cycle registered read; no reset on contents.
module xlr8_ram_1p #(
    parameter int MEM_SIZE = 4096,
    parameter int AW       = $clog2(MEM_SIZE)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [MEM_SIZE];
    logic [7:0] r_rdata;

    // Write port and synchronous read share the single address.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/xlr8_dmem_mc_xb.sv
// Multi-channel data-memory crossbar: CPU register window, N prefetching
// address channels and a round-robin fetch arbiter over one single-port memory.
module xlr8_dmem_mc_xb
    import xlr8_dmem_mc_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hE0,
    parameter int         NUM_CH    = 2,
    parameter int         MEM_SIZE  = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dbus_in,
    output logic [7:0] dbus_out,
    output logic       io_out_en,
    input  logic [7:0] ramadr,
    input  logic       ramre,
    input  logic       ramwe,
    input  logic       dm_sel
);

    localparam int         AW       = $clog2(MEM_SIZE);
    localparam logic [8:0] LAST_OFF = 9'(1 + 4 * NUM_CH);

    logic [8:0]  w_off;
    logic        w_in_win;
    logic        w_rd;
    logic        w_wr;
    logic        w_is_ch;
    logic [3:0]  w_ch_off;
    logic [1:0]  w_ch_idx;
    logic [1:0]  w_fld;
    logic        w_data_rd;
    logic        w_data_wr;
    logic        w_mem_wr;
    logic [15:0] w_cur_addr;
    logic [7:0]  w_cur_stride;
    logic [7:0]  w_cur_data;
    logic        w_cur_valid;
    logic        w_cur_oor;
    logic [3:0]  w_valid4;
    logic [AW-1:0] w_fetch_addr;
    logic [AW-1:0] w_mem_addr;
    logic [7:0]  w_rdata;
    logic        w_gnt_any;
    logic [1:0]  w_gnt_idx;

    logic [15:0] w_ch_addr   [NUM_CH];
    logic [7:0]  w_ch_stride [NUM_CH];
    logic [7:0]  w_ch_data   [NUM_CH];
    logic [NUM_CH-1:0] w_ch_valid;
    logic [NUM_CH-1:0] w_ch_oor;
    logic [NUM_CH-1:0] w_ch_sel;
    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_grant;
    logic [NUM_CH-1:0] w_hit;

    logic       r_wrap;
    logic       r_clr;
    logic       r_underrun;
    logic       r_oor;
    logic [1:0] r_last;

    assign w_off    = {1'b0, ramadr} - {1'b0, BASE_ADDR};
    assign w_in_win = ({1'b0, ramadr} >= {1'b0, BASE_ADDR}) && (w_off <= LAST_OFF);
    assign w_rd     = dm_sel & ramre & w_in_win & ~rst;
    assign w_wr     = dm_sel & ramwe & w_in_win & ~rst;
    assign w_is_ch  = (w_off >= OFF_CH0);
    assign w_ch_off = w_off[3:0] - 4'd2;
    assign w_ch_idx = w_ch_off[3:2];
    assign w_fld    = w_ch_off[1:0];

    assign w_data_rd = w_rd & w_is_ch & (w_fld == FLD_DATA);
    assign w_data_wr = w_wr & w_is_ch & (w_fld == FLD_DATA);
    assign w_mem_wr  = w_data_wr & ~w_cur_oor;

    // Mux the addressed channel's state onto shared wires.
    always_comb begin
        w_cur_addr   = 16'h0000;
        w_cur_stride = 8'h00;
        w_cur_data   = 8'h00;
        w_cur_valid  = 1'b0;
        w_cur_oor    = 1'b0;
        w_valid4     = 4'b0000;
        for (int c = 0; c < NUM_CH; c++) begin
            w_valid4[c] = w_ch_valid[c];
            if (w_ch_idx == 2'(c)) begin
                w_cur_addr   = w_ch_addr[c];
                w_cur_stride = w_ch_stride[c];
                w_cur_data   = w_ch_data[c];
                w_cur_valid  = w_ch_valid[c];
                w_cur_oor    = w_ch_oor[c];
            end else begin
                w_cur_addr = w_cur_addr;
            end
        end
    end

    // Round-robin: first requesting channel after the last one granted.
    always_comb begin
        w_grant      = '0;
        w_gnt_any    = 1'b0;
        w_gnt_idx    = r_last;
        w_fetch_addr = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            int idx;
            idx = int'(r_last) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end else begin
                idx = idx;
            end
            if (!w_gnt_any && !w_mem_wr && w_req[idx]) begin
                w_gnt_any    = 1'b1;
                w_gnt_idx    = 2'(idx);
                w_grant[idx] = 1'b1;
                w_fetch_addr = w_ch_addr[idx][AW-1:0];
            end else begin
                w_gnt_any = w_gnt_any;
            end
        end
    end

    assign w_mem_addr = w_mem_wr ? w_cur_addr[AW-1:0] : w_fetch_addr;

    genvar gc;
    generate
        for (gc = 0; gc < NUM_CH; gc++) begin : g_ch
            assign w_ch_sel[gc] = w_is_ch && (w_ch_idx == 2'(gc));
            assign w_hit[gc]    = w_mem_wr && (w_ch_addr[gc] == w_cur_addr);

            xlr8_dmem_mc_chan #(
                .MEM_SIZE (MEM_SIZE)
            ) u_chan (
                .i_clk       (clk),
                .i_rst       (rst),
                .i_wrap      (r_wrap),
                .i_wr_adrl   (w_wr & w_ch_sel[gc] & (w_fld == FLD_ADRL)),
                .i_wr_adrh   (w_wr & w_ch_sel[gc] & (w_fld == FLD_ADRH)),
                .i_wr_stride (w_wr & w_ch_sel[gc] & (w_fld == FLD_STRIDE)),
                .i_data_acc  ((w_wr | w_rd) & w_ch_sel[gc] & (w_fld == FLD_DATA)),
                .i_hit       (w_hit[gc]),
                .i_wdata     (dbus_in),
                .i_grant     (w_grant[gc]),
                .i_rdata     (w_rdata),
                .o_addr      (w_ch_addr[gc]),
                .o_stride    (w_ch_stride[gc]),
                .o_data      (w_ch_data[gc]),
                .o_valid     (w_ch_valid[gc]),
                .o_req       (w_req[gc]),
                .o_oor       (w_ch_oor[gc])
            );
        end
    endgenerate

    xlr8_ram_1p #(
        .MEM_SIZE (MEM_SIZE)
    ) u_ram (
        .i_clk   (clk),
        .i_we    (w_mem_wr),
        .i_addr  (w_mem_addr),
        .i_wdata (dbus_in),
        .o_rdata (w_rdata)
    );

    // Control register, CLR pulse, sticky status flags and arbiter pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap     <= 1'b0;
            r_clr      <= 1'b0;
            r_underrun <= 1'b0;
            r_oor      <= 1'b0;
            r_last     <= 2'(NUM_CH - 1);
        end else begin
            if (w_wr && (w_off == OFF_CTRL)) begin
                r_wrap <= dbus_in[CTRL_WRAP];
                r_clr  <= dbus_in[CTRL_CLR];
            end else begin
                r_clr  <= 1'b0;
            end
            if (w_wr && (w_off == OFF_CTRL) && dbus_in[CTRL_CLR]) begin
                r_underrun <= 1'b0;
                r_oor      <= 1'b0;
            end else begin
                if (w_data_rd && !w_cur_valid && !w_cur_oor) begin
                    r_underrun <= 1'b1;
                end
                if ((w_data_rd || w_data_wr) && w_cur_oor) begin
                    r_oor <= 1'b1;
                end
            end
            if (w_gnt_any) begin
                r_last <= w_gnt_idx;
            end
        end
    end

    // CPU read data; out-of-range DATA reads return zero.
    always_comb begin
        dbus_out  = 8'h00;
        io_out_en = w_rd;
        if (!w_rd) begin
            dbus_out = 8'h00;
        end else if (w_off == OFF_CTRL) begin
            dbus_out = {6'b000000, r_clr, r_wrap};
        end else if (w_off == OFF_STATUS) begin
            dbus_out = {r_underrun, r_oor, 2'b00, w_valid4};
        end else begin
            case (w_fld)
                FLD_ADRL:   dbus_out = w_cur_addr[7:0];
                FLD_ADRH:   dbus_out = w_cur_addr[15:8];
                FLD_STRIDE: dbus_out = w_cur_stride;
                FLD_DATA:   dbus_out = w_cur_oor ? 8'h00 : w_cur_data;
                default:    dbus_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_xlr8_dmem_mc_xb.sv
// Scoreboard bench for xlr8_dmem_mc_xb with default parameters (window E0..E9).
module tb_xlr8_dmem_mc_xb;

    localparam logic [7:0] A_CTRL = 8'hE0, A_STAT = 8'hE1;
    localparam logic [7:0] A0_L = 8'hE2, A0_H = 8'hE3, A0_S = 8'hE4, A0_D = 8'hE5;
    localparam logic [7:0] A1_L = 8'hE6, A1_H = 8'hE7, A1_S = 8'hE8, A1_D = 8'hE9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dbus_in = 8'h00;
    logic [7:0] dbus_out;
    logic       io_out_en;
    logic [7:0] ramadr = 8'h00;
    logic       ramre = 1'b0;
    logic       ramwe = 1'b0;
    logic       dm_sel = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q  [$];
    string      name_q [$];

    always #5 clk = ~clk;

    xlr8_dmem_mc_xb dut (
        .clk       (clk),
        .rst       (rst),
        .dbus_in   (dbus_in),
        .dbus_out  (dbus_out),
        .io_out_en (io_out_en),
        .ramadr    (ramadr),
        .ramre     (ramre),
        .ramwe     (ramwe),
        .dm_sel    (dm_sel)
    );

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    // Monitor: every presented read is matched against the oldest expectation.
    always @(negedge clk) begin
        if (io_out_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_read: io_out_en high at %02h, nothing expected", ramadr);
            end else begin
                string nm;
                logic [7:0] e;
                nm = name_q.pop_front();
                e  = exp_q.pop_front();
                check(nm, dbus_out, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        ramadr = a;
        dbus_in = d;
        ramwe = 1'b1;
        tick();
        ramwe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        ramadr = a;
        ramre = 1'b1;
        tick();
        ramre = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic reset_pulse(input string nm);
        rst = 1'b1;
        ramadr = A_STAT;
        ramre = 1'b1;
        tick();
        @(negedge clk);
        check({nm, "_io_out_en"}, {7'd0, io_out_en}, 8'h00);
        check({nm, "_dbus_out"}, dbus_out, 8'h00);
        @(posedge clk);
        #1;
        ramre = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        reset_pulse("rst0");
        idle(4);
        rd(A_STAT, 8'h03, "rst_status_valid");
        rd(A_CTRL, 8'h00, "rst_ctrl");
        rd(A0_L,   8'h00, "rst_ch0_adrl");
        rd(A0_H,   8'h00, "rst_ch0_adrh");
        rd(A0_S,   8'h01, "rst_ch0_stride");
        rd(A1_S,   8'h01, "rst_ch1_stride");

        // Sequential write then reload and read back.
        wr(A0_H, 8'h01);
        wr(A0_L, 8'h00);
        wr(A0_D, 8'hAA);
        wr(A0_D, 8'hBB);
        wr(A0_L, 8'h00);
        idle(3);
        rd(A0_D, 8'hAA, "seq_read0");
        idle(3);
        rd(A0_D, 8'hBB, "seq_read1");
        rd(A0_L, 8'h02, "seq_adrl");
        rd(A0_H, 8'h01, "seq_adrh");

        // Negative stride with WRAP from address 0.
        wr(A_CTRL, 8'h01);
        wr(A1_S, 8'hFF);
        wr(A1_D, 8'h3C);
        rd(A1_L, 8'hFF, "wrap_wr_adrl");
        rd(A1_H, 8'h0F, "wrap_wr_adrh");
        wr(A1_H, 8'h00);
        wr(A1_L, 8'h00);
        idle(3);
        rd(A1_D, 8'h3C, "wrap_read_data");
        rd(A1_H, 8'h0F, "wrap_rd_adrh");
        rd(A_CTRL, 8'h01, "ctrl_wrap");

        // Write-invalidate of a second channel on the same address.
        wr(A1_S, 8'h01);
        wr(A0_H, 8'h00);
        wr(A0_L, 8'h20);
        wr(A1_H, 8'h00);
        wr(A1_L, 8'h20);
        idle(4);
        rd(A_STAT, 8'h03, "coh_both_valid");
        wr(A0_D, 8'h55);
        rd(A_STAT, 8'h00, "coh_both_invalid");
        idle(2);
        rd(A1_D, 8'h55, "coh_ch1_sees_write");

        // Underrun on an immediate read, then CLR.
        wr(A1_L, 8'h20);
        rd(A1_D, 8'h55, "underrun_stale");
        rd(A_STAT, 8'h81, "underrun_status");
        wr(A_CTRL, 8'h02);
        rd(A_STAT, 8'h03, "clr_status");
        rd(A_CTRL, 8'h00, "clr_selfclear");

        // Out-of-range access with WRAP=0.
        wr(A0_H, 8'h10);
        wr(A0_L, 8'h00);
        wr(A0_D, 8'h77);
        rd(A0_L, 8'h01, "oor_advance");
        wr(A0_L, 8'h00);
        rd(A0_D, 8'h00, "oor_read_zero");
        rd(A_STAT, 8'h42, "oor_status");
        wr(A1_H, 8'h00);
        wr(A1_L, 8'h00);
        idle(3);
        rd(A1_D, 8'h3C, "oor_mem_unchanged");

        // Reset while ch0 has a fetch in flight.
        wr(A0_H, 8'h00);
        idle(1);
        reset_pulse("rst_mid");
        rd(A_STAT, 8'h00, "rst_mid_status0");
        idle(1);
        rd(A_STAT, 8'h01, "rst_mid_ch0_valid");
        rd(A0_D, 8'h3C, "rst_mid_ch0_data");
        rd(A0_L, 8'h01, "rst_mid_ch0_adrl");
        rd(A0_H, 8'h00, "rst_mid_ch0_adrh");
        rd(A_CTRL, 8'h00, "rst_mid_ctrl");

        idle(2);
        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
